seq_detect_param: RTL and testbench

Parametrised serial pattern detector for single-bit streams. It replaces the fixed-pattern, fixed-length detector. Pattern length is set by a parameter; the pattern value is loadable at run time; overlapping or non-overlapping matching is selectable; a qualifying valid strobe lets the stream stall; a saturating match counter is provided. It sits on the serial input path and feeds downstream control logic.

---
 rtl/seq_detect_param.sv | 83 ++++++++
 tb/tb_seq_detect_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial pattern detector.
// Shifts qualified serial bits into a history register and compares it with a
// run-time loadable pattern. It produces a registered one-cycle match pulse
// and keeps a saturating match counter.
//
// Stream handshake: x is consumed on every rising edge where x_valid=1.
// There is no ready; the detector always accepts and never applies
// back-pressure. An edge with x_valid=0 is a stall: history and fill hold,
// and y drops.
module seq_detect_param #(
    parameter int             N           = 4,
    parameter logic [N-1:0]   DEF_PATTERN = 4'b1011,
    parameter int             CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] match_cnt
);

    // fill counts 0..N, so it needs enough bits to hold N itself.
    localparam int             FW       = $clog2(N + 1);
    localparam logic [FW-1:0]  FILL_MAX = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N-1:0]  pat_reg;
    logic [N-1:0]  hist;
    logic [FW-1:0] fill;

    logic [N-1:0]  hist_n;
    logic [FW-1:0] fill_n;
    logic          match;

    // Next history/fill for a sample edge, and whether that edge completes a match.
    always_comb begin
        hist_n = {hist[N-2:0], x};
        fill_n = (fill == FILL_MAX) ? fill : fill + 1'b1;
        match  = x_valid && !pat_load && (fill_n == FILL_MAX) && (hist_n == pat_reg);
    end

    // Pattern, history, fill and match pulse. A pattern load wins over a sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_reg <= DEF_PATTERN;
            hist    <= '0;
            fill    <= '0;
            y       <= 1'b0;
        end else if (pat_load) begin
            pat_reg <= pat_in;
            fill    <= '0;
            y       <= 1'b0;
        end else if (x_valid) begin
            hist <= hist_n;
            // Non-overlapping mode forces the next match to use N fresh bits.
            fill <= (match && !overlap) ? '0 : fill_n;
            y    <= match;
        end else begin
            y <= 1'b0;
        end
    end

    // Saturating match counter; a clear coinciding with a match leaves a count of one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_cnt <= '0;
        end else if (match) begin
            if (clr_cnt)
                match_cnt <= CNT_ONE;
            else if (match_cnt != CNT_MAX)
                match_cnt <= match_cnt + 1'b1;
        end else if (clr_cnt) begin
            match_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param: directed scenarios plus a randomized stream.
// Two instances share all inputs: one with an 8-bit counter and one with a
// 2-bit counter, so that saturation can be checked.
module tb_seq_detect_param;

    localparam int N = 4;
    localparam logic [N-1:0] DEF_PAT = 4'b1011;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic         x = 1'b0, x_valid = 1'b0, pat_load = 1'b0, overlap = 1'b1, clr_cnt = 1'b0;
    logic [N-1:0] pat_in = '0;
    logic         y_a, y_b;
    logic [7:0]   cnt_a;
    logic [1:0]   cnt_b;

    seq_detect_param #(.N(N), .DEF_PATTERN(DEF_PAT), .CNT_W(8)) u_dut_a (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .clr_cnt(clr_cnt), .y(y_a), .match_cnt(cnt_a)
    );

    seq_detect_param #(.N(N), .DEF_PATTERN(DEF_PAT), .CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .pat_load(pat_load),
        .pat_in(pat_in), .overlap(overlap), .clr_cnt(clr_cnt), .y(y_b), .match_cnt(cnt_b)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_pass   = 0;

    // Reference: bits received since the last pattern load, reset or
    // non-overlapping match, trimmed to the most recent N.
    bit           bits_q[$];
    logic [N-1:0] pat_m   = DEF_PAT;
    int           cnt_m_a = 0;
    int           cnt_m_b = 0;
    logic [31:0]  exp_q[$];   // expected y per edge, consumed in order

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        bits_q.delete();
        pat_m   = DEF_PAT;
        cnt_m_a = 0;
        cnt_m_b = 0;
    endtask

    // ---------------- driver ----------------
    // Drive one edge's inputs, update the model, then check after the edge.
    task automatic step(input bit xv, input bit xb, input bit pl, input logic [N-1:0] pi,
                        input bit ov, input bit clr);
        bit hit;
        int val;
        x = xb; x_valid = xv; pat_load = pl; pat_in = pi; overlap = ov; clr_cnt = clr;
        hit = 1'b0;
        if (pl) begin
            pat_m = pi;
            bits_q.delete();
        end else if (xv) begin
            bits_q.push_back(xb);
            if (bits_q.size() > N) void'(bits_q.pop_front());
            if (bits_q.size() == N) begin
                val = 0;
                foreach (bits_q[i]) val = val * 2 + int'(bits_q[i]);
                hit = (val == int'(pat_m));
                if (hit && !ov) bits_q.delete();
            end
        end
        if (hit) begin
            cnt_m_a = clr ? 1 : ((cnt_m_a == 255) ? 255 : cnt_m_a + 1);
            cnt_m_b = clr ? 1 : ((cnt_m_b == 3) ? 3 : cnt_m_b + 1);
        end else if (clr) begin
            cnt_m_a = 0;
            cnt_m_b = 0;
        end
        exp_q.push_back(32'(hit));
        @(posedge clk);
        #1;
        begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("y_a", 32'(y_a), e);
            check("y_b", 32'(y_b), e);
        end
        check("cnt_a", 32'(cnt_a), 32'(cnt_m_a));
        check("cnt_b", 32'(cnt_b), 32'(cnt_m_b));
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0, '0, ov, 1'b0);
    endtask

    task automatic load_pat(input logic [N-1:0] p, input bit clr);
        step(1'b0, 1'b0, 1'b1, p, overlap, clr);
    endtask

    // Assert reset asynchronously between edges, check outputs immediately, hold 2 edges.
    task automatic do_reset();
        reset = 1'b0;
        x_valid = 1'b0; pat_load = 1'b0; clr_cnt = 1'b0;
        #1;
        check("rst_y_a", 32'(y_a), 32'd0);
        check("rst_y_b", 32'(y_b), 32'd0);
        check("rst_cnt_a", 32'(cnt_a), 32'd0);
        check("rst_cnt_b", 32'(cnt_b), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_y", 32'(y_a), 32'd0);
        reset = 1'b1;
    endtask

    // Watchdog: the run is bounded in time regardless of DUT behaviour.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        // Reset state.
        #3;
        check("init_y", 32'(y_a), 32'd0);
        check("init_cnt", 32'(cnt_a), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // 1: default pattern, overlapping: pulses after samples 4 and 7.
        send_bits(8'b1011011, 7, 1'b1);
        check("t1_cnt", 32'(cnt_a), 32'd2);

        // 2: same stream, non-overlapping: one pulse.
        load_pat(DEF_PAT, 1'b1);
        send_bits(8'b1011011, 7, 1'b0);
        check("t2_cnt", 32'(cnt_a), 32'd1);

        // 3: pattern 1111, six ones, overlapping then non-overlapping.
        load_pat(4'b1111, 1'b1);
        send_bits(8'b111111, 6, 1'b1);
        check("t3a_cnt", 32'(cnt_a), 32'd3);
        load_pat(4'b1111, 1'b1);
        send_bits(8'b111111, 6, 1'b0);
        check("t3b_cnt", 32'(cnt_a), 32'd1);

        // 4: default pattern with three stall cycles between bits.
        load_pat(DEF_PAT, 1'b1);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] b;
            b = 4'b1011;
            step(1'b1, b[i], 1'b0, '0, 1'b1, 1'b0);
            if (i != 0)
                for (int k = 0; k < 3; k++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b1, 1'b0);
        end
        check("t4_cnt", 32'(cnt_a), 32'd1);

        // 5: reset mid-stream discards 1,0,1; the next 1 must not match.
        send_bits(8'b101, 3, 1'b1);
        do_reset();
        send_bits(8'b1, 1, 1'b1);
        check("t5_nomatch", 32'(cnt_a), 32'd0);
        send_bits(8'b1011, 4, 1'b1);
        check("t5_cnt", 32'(cnt_a), 32'd1);

        // 6: counter saturation on the 2-bit instance, then clear rules.
        load_pat(4'b1111, 1'b1);
        send_bits(8'b11111111, 8, 1'b1);
        check("t6_sat_b", 32'(cnt_b), 32'd3);
        check("t6_cnt_a", 32'(cnt_a), 32'd5);
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b1);   // match and clear together
        check("t6_clr_match", 32'(cnt_b), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);   // clear alone
        check("t6_clr", 32'(cnt_b), 32'd0);

        // Randomized stream: stalls, occasional pattern loads, overlap flips, clears.
        for (int i = 0; i < 600; i++) begin
            bit xv, pl, clr, ov;
            logic [N-1:0] pi;
            xv  = ($urandom_range(0, 9) < 8);
            pl  = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 39) == 0);
            ov  = (i % 150 < 75) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            pi  = N'($urandom_range(0, (1 << N) - 1));
            step(xv, 1'($urandom_range(0, 1)), pl, pi, ov, clr);
            if (i == 300) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
